lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
Parametrised load/store unit that succeeds the fixed-width LSU. Accepts one load or store per handshake from the execute stage. Drives a simple valid/ready memory bus with byte strobes. Returns a single-cycle completion pulse carrying aligned, sign/zero-extended load data and an error flag; the pulse replaces the rd_finish/wr_finish signals of the previous LSU.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus/register data width; legal values 32 or 64
STRB_W, DATA_W/8, byte-strobe width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  execute stage presents a memory op
req_ready  out  1  LSU can accept op
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-aligned
req_size  in  2  0=byte,1=half,2=word,3=dword (dword legal only when DATA_W=64)
req_unsigned  in  1  load zero-extends when 1
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  extended load data; 0 for stores
rsp_err  out  1  misaligned/illegal size/bus error, qualified by rsp_valid
bus_valid  out  1  bus request valid
bus_ready  in  1  bus accepts request
bus_we  out  1  write request
bus_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes
bus_wdata  out  DATA_W  store data shifted to byte lane
bus_wstrb  out  STRB_W  byte enables; all 0 on reads
bus_rvalid  in  1  bus response valid
bus_rready  out  1  LSU accepts response
bus_rdata  in  DATA_W  read data
bus_rerr  in  1  bus error with response

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; bus_valid=0; bus_we=0; bus_addr=0; bus_wdata=0; bus_wstrb=0; bus_rready=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1. When req_valid=1, latch the op and check it:
  - Misaligned (half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0) or illegal size (dword when DATA_W=32) -> RESP with err=1. No bus access is made.
  - Otherwise -> ADDR.
- ADDR: bus_valid=1 with bus_we, bus_addr, bus_wdata and bus_wstrb held stable. Advance to DATA in the cycle bus_valid&&bus_ready.
- DATA: bus_rready=1. On bus_rvalid, capture bus_rdata and bus_rerr, then -> RESP. Write ops also wait for a bus_rvalid acknowledge.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in every state except IDLE.
- Latency with zero-wait bus: request accept to rsp_valid is 3 cycles (IDLE->ADDR->DATA->RESP). Misaligned or illegal ops take 1 cycle.
- Lane offset = addr[log2(STRB_W)-1:0].
- Store: bus_wdata = req_wdata << (8*offset). bus_wstrb = ((1<<bytes)-1) << offset, where bytes = 1/2/4/8.
- Load: shift bus_rdata right by 8*offset, take the low 8/16/32/64 bits, then sign- or zero-extend to DATA_W per req_unsigned. rsp_rdata=0 when err=1.
- A new req_valid is ignored outside IDLE. The requester must hold its op until it sees req_ready.
- If the bus asserts bus_rvalid and bus_ready in the same cycle during ADDR, the response is taken in the next cycle's DATA state. The bus must hold bus_rvalid until bus_rready.
- Reset asserted mid-transaction aborts it and drops bus_valid/bus_rready immediately. No response is emitted.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8-bit watchdog counts cycles spent in ADDR or DATA and clears on every state change. At 255 the FSM abandons the access and goes to RESP with rsp_err=1, rsp_rdata=0. Any late bus_rvalid is then ignored (bus_rready=0 in IDLE).
- Undefined: no counter; the LSU waits indefinitely.

Test Plan:
- Reset mid-ADDR with bus_ready=0 -> outputs return to reset values asynchronously; req_ready=1 after release; no rsp_valid.
- DATA_W=32, store byte 0xAB at addr 0x1003, zero-wait bus -> bus_addr=0x1000, bus_wstrb=4'b1000, bus_wdata=0xAB000000; rsp_valid 3 cycles after accept, rsp_err=0.
- DATA_W=32, signed half load at 0x2002, bus_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001. Same op with req_unsigned=1 -> 0x00008001.
- Word load at 0x3001 -> rsp_valid on the next cycle with rsp_err=1, rsp_rdata=0; bus_valid never asserted. Dword request with DATA_W=32 -> same response.
- DATA_W=64, dword load at 0x8, bus_ready delayed 5 cycles, bus_rerr=1 on response -> bus_valid held stable for 6 cycles; rsp_err=1, rsp_rdata=0.
- LSU_TIMEOUT_EN defined, bus_ready tied 0 -> rsp_valid with rsp_err=1 exactly 255 cycles after entering ADDR; next request accepted normally.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store unit: one op per handshake, valid/ready bus with byte strobes, single-cycle completion pulse.
// Optional watchdog on stalled bus accesses is compiled in with `define LSU_TIMEOUT_EN.
module lsu_bus_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic              bus_rvalid,
   output logic              bus_rready,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rerr
);

   localparam int OFF_W = $clog2(STRB_W);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e state_q, state_d;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              misaligned;
   logic              illegal;
   logic              timeout;
   logic [OFF_W-1:0]  reqOff;
   logic [STRB_W-1:0] sizeMask;
   logic [DATA_W-1:0] laneData;
   logic [DATA_W-1:0] loadExt;

`ifdef LSU_TIMEOUT_EN
   logic [7:0] wdog_q, wdog_d;

   // The watchdog restarts on every state change; the abandon fires while the count reads 254,
   // so the FSM reaches RESP 255 cycles after entering ADDR.
   always_comb begin
      wdog_d = 8'd0;
      if ((state_d == state_q) && ((state_q == ADDR) || (state_q == DATA))) begin
         wdog_d = wdog_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q <= 8'd0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   assign timeout = ((state_q == ADDR) || (state_q == DATA)) && (wdog_q == 8'd254);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      reqOff = req_addr[OFF_W-1:0];
      case (req_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = req_addr[0];
         2'd2:    misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
      case (req_size)
         2'd0:    sizeMask = STRB_W'(8'h01);
         2'd1:    sizeMask = STRB_W'(8'h03);
         2'd2:    sizeMask = STRB_W'(8'h0F);
         default: sizeMask = STRB_W'(8'hFF);
      endcase
      illegal = misaligned || ((req_size == 2'd3) && (DATA_W != 64));
   end

   // Bring the addressed lane down to bit 0, then extend from the access size.
   always_comb begin
      laneData = bus_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    loadExt = uns_q ? DATA_W'(laneData[7:0])  : DATA_W'(signed'(laneData[7:0]));
         2'd1:    loadExt = uns_q ? DATA_W'(laneData[15:0]) : DATA_W'(signed'(laneData[15:0]));
         2'd2:    loadExt = uns_q ? DATA_W'(laneData[31:0]) : DATA_W'(signed'(laneData[31:0]));
         default: loadExt = laneData;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = illegal ? RESP : ADDR;
            end
         end
         ADDR: begin
            if (bus_ready) begin
               state_d = DATA;
            end else if (timeout) begin
               state_d = RESP;
            end
         end
         DATA: begin
            if (bus_rvalid || timeout) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request fields are captured on accept; the bus address is stored already aligned to the bus width.
   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      off_d   = off_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if ((state_q == IDLE) && req_valid) begin
         we_d    = req_we;
         addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         off_d   = reqOff;
         size_d  = req_size;
         uns_d   = req_unsigned;
         wdata_d = req_wdata << {reqOff, 3'b000};
         strb_d  = req_we ? (sizeMask << reqOff) : '0;
         err_d   = illegal;
         rdata_d = '0;
      end else if ((state_q == DATA) && bus_rvalid) begin
         err_d   = bus_rerr;
         rdata_d = (we_q || bus_rerr) ? '0 : loadExt;
      end else if (timeout) begin
         err_d   = 1'b1;
         rdata_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         off_q   <= '0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs are decoded from state so an asynchronous reset drops them immediately.
   always_comb begin
      req_ready  = (state_q == IDLE);
      bus_valid  = (state_q == ADDR);
      bus_we     = (state_q == ADDR) && we_q;
      bus_addr   = (state_q == ADDR) ? addr_q : '0;
      bus_wdata  = (state_q == ADDR) ? wdata_q : '0;
      bus_wstrb  = (state_q == ADDR) ? strb_q : '0;
      bus_rready = (state_q == DATA);
      rsp_valid  = (state_q == RESP);
      rsp_rdata  = (state_q == RESP) ? rdata_q : '0;
      rsp_err    = (state_q == RESP) && err_q;
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed scoreboard bench for lsu_bus_master: a 32-bit and a 64-bit instance share stimulus,
// only the selected one sees req_valid. Watchdog checks run when LSU_TIMEOUT_EN is defined.
module tb_lsu_bus_master;

`ifdef LSU_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          busCyc;
   } exp_t;

   exp_t expQ[$];
   int   compared = 0;
   int   mismatched = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        selWide;
   logic        reqValid;
   logic        reqWe;
   logic [31:0] reqAddr;
   logic [63:0] reqWdata;
   logic [1:0]  reqSize;
   logic        reqUnsigned;
   logic        busReady;
   logic        busRvalid;
   logic [63:0] busRdata;
   logic        busRerr;

   logic        reqValid32, reqReady32, rspValid32, rspErr32, busValid32, busWe32, busRready32;
   logic [31:0] rspRdata32, busAddr32, busWdata32;
   logic [3:0]  busWstrb32;
   logic        reqValid64, reqReady64, rspValid64, rspErr64, busValid64, busWe64, busRready64;
   logic [63:0] rspRdata64, busWdata64;
   logic [31:0] busAddr64;
   logic [7:0]  busWstrb64;

   logic        obsReqReady, obsRspValid, obsRspErr, obsBusValid, obsBusWe, obsBusRready;
   logic [63:0] obsRspRdata, obsBusWdata;
   logic [31:0] obsBusAddr;
   logic [7:0]  obsBusWstrb;

   always #5 clk = ~clk;

   assign reqValid32   = reqValid && !selWide;
   assign reqValid64   = reqValid && selWide;
   assign obsReqReady  = selWide ? reqReady64 : reqReady32;
   assign obsRspValid  = selWide ? rspValid64 : rspValid32;
   assign obsRspErr    = selWide ? rspErr64 : rspErr32;
   assign obsRspRdata  = selWide ? rspRdata64 : {32'h0, rspRdata32};
   assign obsBusValid  = selWide ? busValid64 : busValid32;
   assign obsBusWe     = selWide ? busWe64 : busWe32;
   assign obsBusAddr   = selWide ? busAddr64 : busAddr32;
   assign obsBusWdata  = selWide ? busWdata64 : {32'h0, busWdata32};
   assign obsBusWstrb  = selWide ? busWstrb64 : {4'h0, busWstrb32};
   assign obsBusRready = selWide ? busRready64 : busRready32;

   lsu_bus_master #(.ADDR_W(32), .DATA_W(32)) u32 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid32), .req_ready(reqReady32), .req_we(reqWe), .req_addr(reqAddr),
      .req_wdata(reqWdata[31:0]), .req_size(reqSize), .req_unsigned(reqUnsigned),
      .rsp_valid(rspValid32), .rsp_rdata(rspRdata32), .rsp_err(rspErr32),
      .bus_valid(busValid32), .bus_ready(busReady), .bus_we(busWe32), .bus_addr(busAddr32),
      .bus_wdata(busWdata32), .bus_wstrb(busWstrb32), .bus_rvalid(busRvalid),
      .bus_rready(busRready32), .bus_rdata(busRdata[31:0]), .bus_rerr(busRerr)
   );

   lsu_bus_master #(.ADDR_W(32), .DATA_W(64)) u64 (
      .clk(clk), .rst(rst),
      .req_valid(reqValid64), .req_ready(reqReady64), .req_we(reqWe), .req_addr(reqAddr),
      .req_wdata(reqWdata), .req_size(reqSize), .req_unsigned(reqUnsigned),
      .rsp_valid(rspValid64), .rsp_rdata(rspRdata64), .rsp_err(rspErr64),
      .bus_valid(busValid64), .bus_ready(busReady), .bus_we(busWe64), .bus_addr(busAddr64),
      .bus_wdata(busWdata64), .bus_wstrb(busWstrb64), .bus_rvalid(busRvalid),
      .bus_rready(busRready64), .bus_rdata(busRdata), .bus_rerr(busRerr)
   );

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference load: pick bytes starting at the lane offset, then fill upward byte by byte.
   function automatic logic [63:0] loadModel(input logic [63:0] raw, input int off, input int bytes,
                                             input bit uns, input int dw);
      logic [63:0] r;
      logic        sgn;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < bytes && (i + off) < 8) r[8*i +: 8] = raw[8*(i+off) +: 8];
      end
      sgn = r[8*bytes-1];
      for (int i = 0; i < 8; i++) begin
         if (i >= bytes && i < dw/8) r[8*i +: 8] = (sgn && !uns) ? 8'hFF : 8'h00;
      end
      return r;
   endfunction

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " req_ready"}, obsReqReady, 1);
      checkOutput({tag, " rsp_valid"}, obsRspValid, 0);
      checkOutput({tag, " rsp_rdata"}, obsRspRdata, 0);
      checkOutput({tag, " rsp_err"}, obsRspErr, 0);
      checkOutput({tag, " bus_valid"}, obsBusValid, 0);
      checkOutput({tag, " bus_we"}, obsBusWe, 0);
      checkOutput({tag, " bus_addr"}, obsBusAddr, 0);
      checkOutput({tag, " bus_wdata"}, obsBusWdata, 0);
      checkOutput({tag, " bus_wstrb"}, obsBusWstrb, 0);
      checkOutput({tag, " bus_rready"}, obsBusRready, 0);
   endtask

   // One complete op from a negedge in IDLE; the bus raises bus_ready after readyDelay ADDR cycles.
   task automatic applyStimulus(input string tag, input bit wide, input bit we, input logic [31:0] addr,
                                input logic [63:0] wdata, input logic [1:0] size, input bit uns,
                                input logic [63:0] raw, input bit rerr, input int readyDelay,
                                input bit earlyRvalid);
      int          dw;
      int          bytes;
      int          off;
      int          cyc;
      int          busCyc;
      bit          illegal;
      bit          done;
      exp_t        e;
      exp_t        got;
      logic [31:0] expAddr;
      logic [7:0]  expStrb;
      logic [63:0] expWdata;

      dw      = wide ? 64 : 32;
      bytes   = 1 << size;
      off     = int'(addr) % (dw/8);
      illegal = ((int'(addr) % bytes) != 0) || (size == 2'd3 && !wide);
      expAddr = addr & ~32'(dw/8 - 1);
      expStrb = '0;
      expWdata = '0;
      for (int i = 0; i < dw/8; i++) begin
         expStrb[i] = we && (i >= off) && (i < off + bytes);
         if (i >= off) expWdata[8*i +: 8] = wdata[8*(i-off) +: 8];
      end
      if (illegal) begin
         e.rdata = '0; e.err = 1'b1; e.lat = 1; e.busCyc = 0;
      end else if (TMO && readyDelay + 1 > 255) begin
         e.rdata = '0; e.err = 1'b1; e.lat = 256; e.busCyc = 255;
      end else begin
         e.err    = rerr;
         e.rdata  = (we || rerr) ? 64'h0 : loadModel(raw, off, bytes, uns, dw);
         e.lat    = readyDelay + 3;
         e.busCyc = readyDelay + 1;
      end
      expQ.push_back(e);

      selWide     = wide;
      reqWe       = we;
      reqAddr     = addr;
      reqWdata    = wdata;
      reqSize     = size;
      reqUnsigned = uns;
      reqValid    = 1'b1;
      checkOutput({tag, " req_ready"}, obsReqReady, 1);
      @(negedge clk);
      reqValid    = 1'b0;
      reqAddr     = $urandom;
      reqWdata    = {$urandom, $urandom};
      reqSize     = 2'($urandom_range(0, 3));
      reqUnsigned = 1'($urandom_range(0, 1));
      cyc    = 1;
      busCyc = 0;
      done   = 1'b0;
      while (!done && cyc < 400) begin
         if (obsRspValid) begin
            done = 1'b1;
         end else begin
            if (obsBusValid) begin
               busCyc++;
               checkOutput({tag, " bus_addr"}, obsBusAddr, expAddr);
               checkOutput({tag, " bus_wstrb"}, obsBusWstrb, expStrb);
               checkOutput({tag, " bus_we"}, obsBusWe, we);
               if (we) checkOutput({tag, " bus_wdata"}, obsBusWdata, expWdata);
               busReady = (busCyc > readyDelay);
               if (earlyRvalid && busReady) begin
                  busRvalid = 1'b1; busRdata = raw; busRerr = rerr;
               end
            end else begin
               busReady = 1'b0;
            end
            if (obsBusRready) begin
               busRvalid = 1'b1; busRdata = raw; busRerr = rerr;
            end
            @(negedge clk);
            cyc++;
         end
      end
      busReady  = 1'b0;
      busRvalid = 1'b0;
      busRdata  = '0;
      busRerr   = 1'b0;
      got = expQ.pop_front();
      if (!done) begin
         checkOutput({tag, " rsp_valid within bound"}, obsRspValid, 1);
      end else begin
         checkOutput({tag, " latency"}, 64'(cyc), 64'(got.lat));
         checkOutput({tag, " rsp_err"}, obsRspErr, got.err);
         checkOutput({tag, " rsp_rdata"}, obsRspRdata, got.rdata);
         checkOutput({tag, " bus_valid cycles"}, 64'(busCyc), 64'(got.busCyc));
         @(negedge clk);
         checkOutput({tag, " rsp_valid pulse"}, obsRspValid, 0);
         checkOutput({tag, " req_ready back"}, obsReqReady, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      rst = 1'b0; selWide = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
      reqSize = 2'd0; reqUnsigned = 1'b0; busReady = 1'b0; busRvalid = 1'b0; busRdata = '0; busRerr = 1'b0;
      repeat (2) @(negedge clk);
      checkIdleOutputs("reset32");
      selWide = 1'b1;
      #1 checkIdleOutputs("reset64");
      selWide = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] 32-bit directed ops");
      applyStimulus("st_byte_1003", 0, 1, 32'h1003, 64'hAB, 2'd0, 0, 64'h0, 0, 0, 0);
      applyStimulus("ld_half_s", 0, 0, 32'h2002, 64'h0, 2'd1, 0, 64'h8001_1234, 0, 0, 0);
      applyStimulus("ld_half_u", 0, 0, 32'h2002, 64'h0, 2'd1, 1, 64'h8001_1234, 0, 0, 0);
      applyStimulus("ld_word_misal", 0, 0, 32'h3001, 64'h0, 2'd2, 0, 64'hDEAD_BEEF, 0, 0, 0);
      applyStimulus("ld_dword_32", 0, 0, 32'h3000, 64'h0, 2'd3, 0, 64'hDEAD_BEEF, 0, 0, 0);
      applyStimulus("st_half_early", 0, 1, 32'h0012, 64'hBEEF, 2'd1, 0, 64'h0, 0, 2, 1);
      applyStimulus("ld_byte_s", 0, 0, 32'h0005, 64'h0, 2'd0, 0, 64'h0000_9C00, 0, 1, 0);
      applyStimulus("ld_word_rerr", 0, 0, 32'h0044, 64'h0, 2'd2, 0, 64'h1234_5678, 1, 0, 0);
      applyStimulus("ld_word_ok", 0, 0, 32'h0048, 64'h0, 2'd2, 0, 64'hCAFE_F00D, 0, 0, 0);

      $display("[TB] 64-bit directed ops");
      applyStimulus("ld_dword_rerr", 1, 0, 32'h0008, 64'h0, 2'd3, 0, 64'h1122_3344_5566_7788, 1, 5, 0);
      applyStimulus("st_byte_1d", 1, 1, 32'h001D, 64'h5A, 2'd0, 0, 64'h0, 0, 0, 0);
      applyStimulus("ld_word_s64", 1, 0, 32'h0004, 64'h0, 2'd2, 0, 64'h8765_4321_0000_0000, 0, 0, 0);
      applyStimulus("ld_dword_ok", 1, 0, 32'h0010, 64'h0, 2'd3, 0, 64'hFEDC_BA98_7654_3210, 0, 1, 0);
      applyStimulus("ld_dword_misal", 1, 0, 32'h0014, 64'h0, 2'd3, 0, 64'h0, 0, 0, 0);

      $display("[TB] reset during ADDR");
      selWide = 1'b0; reqWe = 1'b0; reqAddr = 32'h40; reqSize = 2'd2; reqValid = 1'b1;
      @(negedge clk);
      reqValid = 1'b0;
      checkOutput("midrst bus_valid before", obsBusValid, 1);
      #2 rst = 1'b0;
      #1 checkIdleOutputs("midrst async");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("midrst no rsp_valid", obsRspValid, 0);
         checkOutput("midrst req_ready", obsReqReady, 1);
      end
      applyStimulus("after_reset", 0, 0, 32'h0050, 64'h0, 2'd0, 1, 64'h0000_00F0, 0, 0, 0);

      if (TMO) begin
         $display("[TB] watchdog");
         applyStimulus("timeout", 0, 0, 32'h0060, 64'h0, 2'd2, 0, 64'h0, 0, 1000, 0);
         applyStimulus("after_timeout", 0, 1, 32'h0062, 64'h1234, 2'd1, 0, 64'h0, 0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
